// File: rtl/msg_seq_pkg.sv
// msg_seq_pkg: shared types and constants for the message sequencer.
//   state_t      - sequencer FSM states
//   CR, LF       - line-ending characters used by the optional tail
//   *_DEF        - default parameter values for msg_sequencer / pace_timer
package msg_seq_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SEEK  = 3'd1,
      FETCH = 3'd2,
      SEND  = 3'd3,
      NEXT  = 3'd4,
      DONE  = 3'd5
   } state_t;

   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] LF = 8'h0A;

   localparam int N_SEG_DEF    = 4;
   localparam int ADDR_W_DEF   = 6;
   localparam int LEN_W_DEF    = 6;
   localparam int DATA_W_DEF   = 8;
   localparam int CHAR_DIV_DEF = 78105;
   localparam int DIV_W_DEF    = 17;

endpackage

// File: rtl/msg_sequencer_pace.sv
// pace_timer: loadable down-counter that enforces a minimum spacing between
// character start pulses. After reload it counts CHAR_DIV-1 down to 0; the
// expired flag is high whenever the count is 0 (including out of reset).
// Ports:
//   sysclk  - system clock
//   rst_n   - synchronous active-low reset (count forced to expired)
//   reload  - load CHAR_DIV-1 this cycle
//   expired - count has reached 0
module pace_timer
   import msg_seq_pkg::*;
#(
   parameter int CHAR_DIV = CHAR_DIV_DEF,
   parameter int DIV_W    = DIV_W_DEF
) (
   input  logic sysclk,
   input  logic rst_n,
   input  logic reload,
   output logic expired
);

   logic [DIV_W-1:0] count;

   // Reload wins over the decrement; the counter parks at 0 once expired.
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (reload) begin
         count <= DIV_W'(CHAR_DIV - 1);
      end else if (count != '0) begin
         count <= count - DIV_W'(1);
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/msg_sequencer.sv
// msg_sequencer: concatenates the segments picked by a select mask into one
// character stream and hands it to a serial transmitter, one character at a
// time, with a minimum start-to-start spacing and a start/busy handshake.
// Supports auto-repeat and runtime-programmable segment tables.
// Optional build macro MSG_SEQ_CRLF_EN: when defined, every message ends with
// a CR LF tail (sent with the same pacing); when undefined there is no tail.
// Ports:
//   sysclk, rst_n      - clock, synchronous active-low reset
//   sel                - segment select mask, latched on go
//   go                 - one-cycle trigger (ignored while a message runs)
//   auto_en            - restart automatically after each message
//   seg_base, seg_len  - flattened per-segment start address / length
//   rom_addr, rom_data - registered address to, data from the character ROM
//   tx_data, tx_start  - character and one-cycle start pulse to transmitter
//   tx_busy            - transmitter busy
//   busy, done         - message in progress / one-cycle completion pulse
module msg_sequencer
   import msg_seq_pkg::*;
#(
   parameter int N_SEG    = N_SEG_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int LEN_W    = LEN_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int CHAR_DIV = CHAR_DIV_DEF,
   parameter int DIV_W    = DIV_W_DEF
) (
   input  logic                    sysclk,
   input  logic                    rst_n,
   input  logic [N_SEG-1:0]        sel,
   input  logic                    go,
   input  logic                    auto_en,
   input  logic [N_SEG*ADDR_W-1:0] seg_base,
   input  logic [N_SEG*LEN_W-1:0]  seg_len,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_data,
   output logic [DATA_W-1:0]       tx_data,
   output logic                    tx_start,
   input  logic                    tx_busy,
   output logic                    busy,
   output logic                    done
);

   // seg_idx must be able to hold N_SEG so SEEK can see "past the last one".
   localparam int IDX_W  = $clog2(N_SEG + 1);
   localparam int SIDX_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;

`ifdef MSG_SEQ_CRLF_EN
   localparam bit CRLF_EN = 1'b1;
`else
   localparam bit CRLF_EN = 1'b0;
`endif

   // An empty mask still has to walk SEEK when a tail must be sent.
   localparam state_t EMPTY_GO  = CRLF_EN ? SEEK : DONE;
   localparam state_t SEEK_EXIT = CRLF_EN ? SEND : DONE;

   state_t               state;
   state_t               next_state;
   logic [N_SEG-1:0]     sel_q;
   logic [IDX_W-1:0]     seg_idx;
   logic [LEN_W-1:0]     offset;
   logic                 loaded;
   logic                 tail;
   logic                 tail_lf;
   logic                 pace_expired;

   logic [ADDR_W-1:0]    base_arr [N_SEG];
   logic [LEN_W-1:0]     len_arr  [N_SEG];
   logic [SIDX_W-1:0]    idx_lo;
   logic                 in_range;
   logic [ADDR_W-1:0]    cur_base;
   logic [LEN_W-1:0]     cur_len;
   logic                 seg_hit;
   logic                 last_char;
   logic                 restart;

   for (genvar g = 0; g < N_SEG; g++) begin : g_unpack
      assign base_arr[g] = seg_base[g*ADDR_W +: ADDR_W];
      assign len_arr[g]  = seg_len[g*LEN_W +: LEN_W];
   end

   assign idx_lo   = seg_idx[SIDX_W-1:0];
   assign in_range = (seg_idx < IDX_W'(N_SEG));

   // Table lookups for the current segment; an out-of-range index reads as
   // an empty, unselected segment.
   always_comb begin
      cur_base = '0;
      cur_len  = '0;
      seg_hit  = 1'b0;
      if (in_range) begin
         cur_base = base_arr[idx_lo];
         cur_len  = len_arr[idx_lo];
         seg_hit  = sel_q[idx_lo] && (len_arr[idx_lo] != '0);
      end
   end

   assign last_char = ((offset + LEN_W'(1)) == cur_len);
   assign restart   = ((state == IDLE) && go) || ((state == DONE) && auto_en);

   pace_timer #(
      .CHAR_DIV (CHAR_DIV),
      .DIV_W    (DIV_W)
   ) u_pace (
      .sysclk  (sysclk),
      .rst_n   (rst_n),
      .reload  (tx_start),
      .expired (pace_expired)
   );

   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // SEND spends one cycle capturing the ROM character (loaded=0) before it
   // may pulse, so tx_data is already stable in the tx_start cycle.
   always_comb begin
      next_state = state;
      tx_start   = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (go) begin
               next_state = (sel == '0) ? EMPTY_GO : SEEK;
            end
         end
         SEEK: begin
            busy = 1'b1;
            if (!in_range) begin
               next_state = SEEK_EXIT;
            end else if (seg_hit) begin
               next_state = FETCH;
            end
         end
         FETCH: begin
            busy       = 1'b1;
            next_state = SEND;
         end
         SEND: begin
            busy = 1'b1;
            if (loaded && pace_expired && !tx_busy) begin
               tx_start   = 1'b1;
               next_state = NEXT;
            end
         end
         NEXT: begin
            busy = 1'b1;
            if (tail) begin
               next_state = tail_lf ? DONE : SEND;
            end else if (last_char) begin
               next_state = SEEK;
            end else begin
               next_state = FETCH;
            end
         end
         DONE: begin
            done = 1'b1;
            if (auto_en) begin
               next_state = (sel == '0) ? EMPTY_GO : SEEK;
            end else begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Datapath: mask latch, segment/offset walk, ROM address and character
   // register, plus the CR/LF tail flags.
   always_ff @(posedge sysclk) begin
      if (!rst_n) begin
         sel_q    <= '0;
         seg_idx  <= '0;
         offset   <= '0;
         rom_addr <= '0;
         tx_data  <= '0;
         loaded   <= 1'b0;
         tail     <= 1'b0;
         tail_lf  <= 1'b0;
      end else begin
         loaded <= (state == SEND) && (next_state == SEND);
         if (restart) begin
            sel_q   <= sel;
            seg_idx <= '0;
            offset  <= '0;
            tail    <= 1'b0;
            tail_lf <= 1'b0;
         end
         case (state)
            SEEK: begin
               if (!in_range) begin
                  tail <= CRLF_EN;
               end else if (!seg_hit) begin
                  seg_idx <= seg_idx + IDX_W'(1);
               end
            end
            FETCH: begin
               rom_addr <= cur_base + ADDR_W'(offset);
            end
            SEND: begin
               if (!loaded) begin
                  tx_data <= tail ? (tail_lf ? DATA_W'(LF) : DATA_W'(CR)) : rom_data;
               end
            end
            NEXT: begin
               if (tail) begin
                  tail_lf <= 1'b1;
               end else if (last_char) begin
                  offset  <= '0;
                  seg_idx <= seg_idx + IDX_W'(1);
               end else begin
                  offset <= offset + LEN_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_msg_sequencer.sv
// tb_msg_sequencer: directed, self-checking bench for msg_sequencer with
// CHAR_DIV=8, bases {0,12,23,31} and lengths {12,11,8,5}. The ROM returns
// 0x40 + address, so every character identifies the address it came from.
// Honours MSG_SEQ_CRLF_EN by expecting the CR LF tail when it is defined.
module tb_msg_sequencer;
   import msg_seq_pkg::*;

   localparam int CHAR_DIV = 8;

`ifdef MSG_SEQ_CRLF_EN
   localparam bit TAIL_EN = 1'b1;
`else
   localparam bit TAIL_EN = 1'b0;
`endif

   logic        sysclk = 1'b0;
   logic        rst_n;
   logic        go;
   logic        auto_en;
   logic        tx_busy;
   logic [3:0]  sel;
   logic [23:0] seg_base;
   logic [23:0] seg_len;
   logic [5:0]  rom_addr;
   logic [7:0]  rom_data;
   logic [7:0]  tx_data;
   logic        tx_start;
   logic        busy;
   logic        done;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int done_cnt = 0;
   int go_cyc = 0;
   logic [7:0] cap_data [$];
   int         cap_cyc  [$];
   logic [7:0] exp_q    [$];

   msg_sequencer #(
      .N_SEG    (4),
      .ADDR_W   (6),
      .LEN_W    (6),
      .DATA_W   (8),
      .CHAR_DIV (CHAR_DIV),
      .DIV_W    (4)
   ) dut (
      .sysclk   (sysclk),
      .rst_n    (rst_n),
      .sel      (sel),
      .go       (go),
      .auto_en  (auto_en),
      .seg_base (seg_base),
      .seg_len  (seg_len),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .busy     (busy),
      .done     (done)
   );

   // Free-running clock and the combinational character ROM.
   always #5 sysclk = ~sysclk;
   assign rom_data = 8'h40 + {2'b00, rom_addr};

   // Cycle counter used to timestamp start pulses.
   always @(posedge sysclk) cyc <= cyc + 1;

   // Monitor on the falling edge: capture every accepted character and count
   // done pulses.
   always @(negedge sysclk) begin
      if (tx_start) begin
         cap_data.push_back(tx_data);
         cap_cyc.push_back(cyc);
      end
      if (done) done_cnt++;
   end

   // Hard stop in case the stimulus itself wedges.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "[TB] watchdog");
   end

   // One comparison: counts it, and on mismatch reports tag/observed/expected.
   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
         $error("[TB] check %s", tag);
      end
   endtask

   // Advance n clocks and settle just after the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic pulse_go();
      go = 1'b1;
      tick(1);
      go = 1'b0;
      go_cyc = cyc;
   endtask

   task automatic wait_done(input int target, input int max_cyc);
      for (int i = 0; i < max_cyc && done_cnt < target; i++) tick(1);
   endtask

   task automatic wait_starts(input int target, input int max_cyc);
      for (int i = 0; i < max_cyc && cap_data.size() < target; i++) tick(1);
   endtask

   // Append the characters one pass with mask s should produce.
   task automatic add_pass(input logic [3:0] s);
      logic [5:0] a;
      for (int sg = 0; sg < 4; sg++) begin
         if (s[sg]) begin
            for (int o = 0; o < int'(seg_len[sg*6 +: 6]); o++) begin
               a = seg_base[sg*6 +: 6] + 6'(o);
               exp_q.push_back(8'h40 + {2'b00, a});
            end
         end
      end
      if (TAIL_EN) begin
         exp_q.push_back(CR);
         exp_q.push_back(LF);
      end
   endtask

   // Compare captured characters from index first against exp_q.
   // mode 1: spacing exactly CHAR_DIV, mode 2: spacing at least CHAR_DIV.
   task automatic check_stream(input string tag, input int first, input int mode);
      int n;
      int bad;
      int d;
      n = cap_data.size() - first;
      check_output({tag, "_count"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < n) check_output($sformatf("%s_char%0d", tag, i), cap_data[first+i], exp_q[i]);
      end
      if (mode != 0) begin
         bad = 0;
         for (int i = first + 1; i < cap_data.size(); i++) begin
            d = cap_cyc[i] - cap_cyc[i-1];
            if ((mode == 1 && d != CHAR_DIV) || (mode == 2 && d < CHAR_DIV)) bad++;
         end
         check_output({tag, "_spacing"}, bad, 0);
      end
   endtask

   // Directed sequence of steps.
   initial begin
      int b;
      int d0;
      rst_n    = 1'b0;
      go       = 1'b0;
      auto_en  = 1'b0;
      tx_busy  = 1'b0;
      sel      = 4'b0000;
      seg_base = {6'd31, 6'd23, 6'd12, 6'd0};
      seg_len  = {6'd5, 6'd8, 6'd11, 6'd12};

      // Reset state.
      tick(3);
      check_output("rst_rom_addr", rom_addr, 6'd0);
      check_output("rst_tx_data", tx_data, 8'h00);
      check_output("rst_tx_start", tx_start, 1'b0);
      check_output("rst_busy", busy, 1'b0);
      check_output("rst_done", done, 1'b0);
      rst_n = 1'b1;
      tick(2);

      // Empty mask: done still pulses, only the tail (if any) is sent.
      $display("[TB] step: sel=0000");
      b = cap_data.size(); d0 = done_cnt; exp_q.delete(); add_pass(4'b0000);
      sel = 4'b0000;
      pulse_go();
      wait_done(d0 + 1, 60);
      tick(12);
      check_output("sel0_done", done_cnt - d0, 1);
      check_stream("sel0", b, 1);

      // Single segment 0.
      $display("[TB] step: sel=0001");
      b = cap_data.size(); d0 = done_cnt; exp_q.delete(); add_pass(4'b0001);
      sel = 4'b0001;
      check_output("t1_busy_before", busy, 1'b0);
      pulse_go();
      check_output("t1_busy_rise", busy, 1'b1);
      wait_done(d0 + 1, 300);
      tick(12);
      check_output("t1_latency", (cap_cyc.size() > b) ? cap_cyc[b] - go_cyc : -1, 3);
      check_output("t1_done", done_cnt - d0, 1);
      check_output("t1_busy_after", busy, 1'b0);
      check_stream("t1", b, 1);

      // Segments 1 and 3.
      $display("[TB] step: sel=1010");
      b = cap_data.size(); d0 = done_cnt; exp_q.delete(); add_pass(4'b1010);
      sel = 4'b1010;
      pulse_go();
      wait_done(d0 + 1, 400);
      tick(12);
      check_output("t2_first", (cap_data.size() > b) ? cap_data[b] : 8'hFF, 8'h4C);
      check_output("t2_done", done_cnt - d0, 1);
      check_stream("t2", b, 1);

      // All segments, segment 2 empty, extra go mid-message.
      $display("[TB] step: sel=1111 len2=0");
      seg_len[17:12] = 6'd0;
      b = cap_data.size(); d0 = done_cnt; exp_q.delete(); add_pass(4'b1111);
      sel = 4'b1111;
      pulse_go();
      wait_starts(b + 3, 100);
      pulse_go();
      wait_done(d0 + 1, 600);
      tick(20);
      check_output("t3_done", done_cnt - d0, 1);
      check_output("t3_busy_after", busy, 1'b0);
      check_stream("t3", b, 1);
      seg_len[17:12] = 6'd8;

      // Transmitter busy for 20 cycles after the first start.
      $display("[TB] step: tx_busy hold");
      b = cap_data.size(); d0 = done_cnt; exp_q.delete(); add_pass(4'b0001);
      sel = 4'b0001;
      pulse_go();
      wait_starts(b + 1, 60);
      tx_busy = 1'b1;
      tick(5);
      check_output("t4_hold_data_a", tx_data, 8'h41);
      tick(15);
      check_output("t4_hold_starts", cap_data.size() - b, 1);
      check_output("t4_hold_data_b", tx_data, 8'h41);
      tx_busy = 1'b0;
      #1;
      check_output("t4_release_start", tx_start, 1'b1);
      wait_done(d0 + 1, 300);
      tick(12);
      check_output("t4_gap", (cap_cyc.size() > b + 1) ? cap_cyc[b+1] - cap_cyc[b] : -1, 21);
      check_stream("t4", b, 0);

      // Auto-repeat, cleared during the third pass.
      $display("[TB] step: auto repeat");
      b = cap_data.size(); d0 = done_cnt; exp_q.delete();
      add_pass(4'b0001); add_pass(4'b0001); add_pass(4'b0001);
      sel = 4'b0001;
      auto_en = 1'b1;
      pulse_go();
      wait_done(d0 + 2, 500);
      auto_en = 1'b0;
      wait_done(d0 + 3, 500);
      tick(30);
      check_output("t5_done", done_cnt - d0, 3);
      check_output("t5_busy_after", busy, 1'b0);
      check_stream("t5", b, 2);

      // Last segment only (tail follows when enabled).
      $display("[TB] step: sel=1000");
      b = cap_data.size(); d0 = done_cnt; exp_q.delete(); add_pass(4'b1000);
      sel = 4'b1000;
      pulse_go();
      wait_done(d0 + 1, 300);
      tick(12);
      check_output("t6_first", (cap_data.size() > b) ? cap_data[b] : 8'hFF, 8'h5F);
      check_output("t6_done", done_cnt - d0, 1);
      check_stream("t6", b, 1);

      // Reset while the 5th character is waiting to go out.
      $display("[TB] step: reset mid-message");
      b = cap_data.size(); d0 = done_cnt;
      sel = 4'b0001;
      pulse_go();
      wait_starts(b + 4, 100);
      tick(3);
      check_output("t7_pre_busy", busy, 1'b1);
      rst_n = 1'b0;
      tick(1);
      check_output("t7_rom_addr", rom_addr, 6'd0);
      check_output("t7_tx_data", tx_data, 8'h00);
      check_output("t7_tx_start", tx_start, 1'b0);
      check_output("t7_busy", busy, 1'b0);
      check_output("t7_done", done, 1'b0);
      rst_n = 1'b1;
      tick(20);
      check_output("t7_starts", cap_data.size() - b, 4);
      check_output("t7_no_done", done_cnt - d0, 0);
      check_output("t7_idle", busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
